// File: rtl/dvs_ravens_pkg.sv
// Shared constants for the event pipeline.
package dvs_ravens_pkg;

   localparam int unsigned EVENT_BITS = 8;

endpackage

// File: rtl/fifo_bus_arbiter_if.sv
// Requester/FIFO side bus of the arbiter; slave = arbiter, master = requesters + FIFO.
interface fifo_bus_arbiter_if #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned EW    = dvs_ravens_pkg::EVENT_BITS
);

   logic [N_REQ-1:0]    fifo_req;
   logic [N_REQ*EW-1:0] fifo_bus_event;
   logic [N_REQ-1:0]    fifo_grant;
   logic                fifo_full;
   logic                fifo_wr_en;
   logic [EW-1:0]       fifo_wr_data;
   logic                busy;
   logic [15:0]         event_count;

   modport slave (
      input  fifo_req,
      input  fifo_bus_event,
      input  fifo_full,
      output fifo_grant,
      output fifo_wr_en,
      output fifo_wr_data,
      output busy,
      output event_count
   );

   modport master (
      output fifo_req,
      output fifo_bus_event,
      output fifo_full,
      input  fifo_grant,
      input  fifo_wr_en,
      input  fifo_wr_data,
      input  busy,
      input  event_count
   );

endinterface

// File: rtl/fifo_bus_arbiter.sv
// Round-robin arbiter moving one event word per grant from N requesters into a FIFO.
module fifo_bus_arbiter #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned EW    = dvs_ravens_pkg::EVENT_BITS
) (
   input  logic              clk,
   input  logic              rst,
   fifo_bus_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = (N_REQ > 2) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_RELEASE
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [N_REQ-1:0] r_grant;
   logic             r_wr_en;
   logic [EW-1:0]    r_wr_data;
   logic             r_busy;
   logic [CNT_W-1:0] r_event_count;

   logic             w_found;
   logic [IDX_W-1:0] w_winner;
   logic [IDX_W:0]   w_idx;
   logic [IDX_W:0]   w_ptr_sum;
   logic [IDX_W-1:0] w_next_ptr;
   logic [EW-1:0]    w_win_word;
   logic [N_REQ-1:0] w_win_onehot;
   logic             w_owner_req;

   // Scan downward so the requester closest above rr_ptr is the last (winning) hit.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
         if (w_idx >= (IDX_W+1)'(N_REQ)) begin
            w_idx = w_idx - (IDX_W+1)'(N_REQ);
         end
         if (bus.fifo_req[w_idx[IDX_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      w_win_word   = '0;
      w_win_onehot = N_REQ'(1) << w_winner;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_winner == IDX_W'(i)) begin
            w_win_word = bus.fifo_bus_event[i*EW +: EW];
         end
      end
      w_ptr_sum  = {1'b0, w_winner} + (IDX_W+1)'(1);
      w_next_ptr = (w_ptr_sum == (IDX_W+1)'(N_REQ)) ? '0 : w_ptr_sum[IDX_W-1:0];
      // The held grant identifies the owner, so its request level is a simple mask.
      w_owner_req = |(bus.fifo_req & r_grant);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_rr_ptr      <= '0;
         r_grant       <= '0;
         r_wr_en       <= 1'b0;
         r_wr_data     <= '0;
         r_busy        <= 1'b0;
         r_event_count <= '0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!bus.fifo_full && w_found) begin
                  r_state   <= ST_GRANT;
                  r_grant   <= w_win_onehot;
                  r_wr_en   <= 1'b1;
                  r_wr_data <= w_win_word;
                  r_rr_ptr  <= w_next_ptr;
                  r_busy    <= 1'b1;
                  if (r_event_count != CNT_MAX) begin
                     r_event_count <= r_event_count + CNT_W'(1);
                  end
               end
            end
            ST_GRANT: begin
               if (!w_owner_req) begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               if (!w_owner_req) begin
                  r_state <= ST_IDLE;
                  r_grant <= '0;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fifo_grant   = r_grant;
   assign bus.fifo_wr_en   = r_wr_en;
   assign bus.fifo_wr_data = r_wr_data;
   assign bus.busy         = r_busy;
   assign bus.event_count  = r_event_count;

endmodule

// File: tb/tb_fifo_bus_arbiter.sv
// Bench for fifo_bus_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_fifo_bus_arbiter;

   localparam int unsigned N  = 2;
   localparam int unsigned EW = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fifo_bus_arbiter_if #(.N_REQ(N), .EW(EW)) bus ();

   fifo_bus_arbiter #(.N_REQ(N), .EW(EW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Model: who owns the bus (-1 = nobody), next search start, last written word, write count.
   int          m_owner = -1;
   int          m_ptr   = 0;
   bit          m_wr    = 1'b0;
   logic [7:0]  m_data  = '0;
   int unsigned m_count = 0;

   function automatic void model_step();
      logic [1:0] r;
      r = bus.fifo_req;
      m_wr = 1'b0;
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_data  = '0;
         m_count = 0;
      end else if (m_owner < 0) begin
         if (!bus.fifo_full && r != 2'b00) begin
            for (int k = 0; k < int'(N); k++) begin
               int c;
               c = (m_ptr + k) % int'(N);
               if (((r >> c) & 2'b01) != 2'b00) begin
                  m_owner = c;
                  break;
               end
            end
            m_wr   = 1'b1;
            m_data = 8'(bus.fifo_bus_event >> (m_owner * 8));
            m_ptr  = (m_owner + 1) % int'(N);
            if (m_count < 65535) m_count = m_count + 1;
         end
      end else if (((r >> m_owner) & 2'b01) == 2'b00) begin
         m_owner = -1;
      end
   endfunction

   function automatic logic [27:0] expv();
      logic [1:0] g;
      g = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
      return {g, m_wr, m_data, (m_owner >= 0), 16'(m_count)};
   endfunction

   function automatic logic [27:0] obs();
      return {bus.fifo_grant, bus.fifo_wr_en, bus.fifo_wr_data, bus.busy, bus.event_count};
   endfunction

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.fifo_req = '0;
      bus.fifo_full = 1'b0;
      bus.fifo_bus_event = '0;
      step();
      step();
      n_checks++;
      if (obs() !== 28'h0) $display("FAIL reset_state got %h want %h", obs(), 28'h0);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_single();
      bus.fifo_bus_event = {8'h3C, 8'hA5};
      bus.fifo_req = 2'b01;
      step();
      n_checks++;
      if (obs() !== {2'b01, 1'b1, 8'hA5, 1'b1, 16'd1})
         $display("FAIL single_first got %h want %h", obs(), {2'b01, 1'b1, 8'hA5, 1'b1, 16'd1});
      else n_pass++;
      for (int c = 0; c < 4; c++) begin
         if (c == 3) bus.fifo_req = 2'b00;
         step();
         n_checks++;
         if (obs() !== expv()) $display("FAIL single_hold c%0d got %h want %h", c, obs(), expv());
         else n_pass++;
      end
   endtask

   task automatic test_full();
      bus.fifo_full = 1'b1;
      bus.fifo_req = 2'b01;
      for (int c = 0; c < 10; c++) begin
         step();
         n_checks++;
         if (obs() !== expv() || bus.fifo_grant !== 2'b00 || bus.fifo_wr_en !== 1'b0)
            $display("FAIL full_block c%0d got %h want %h", c, obs(), expv());
         else n_pass++;
      end
      bus.fifo_full = 1'b0;
      step();
      n_checks++;
      if (obs() !== expv() || bus.fifo_grant !== 2'b01 || bus.fifo_wr_en !== 1'b1)
         $display("FAIL full_release got %h want %h", obs(), expv());
      else n_pass++;
      bus.fifo_req = 2'b00;
      step();
      step();
   endtask

   task automatic test_drop_in_grant();
      bus.fifo_bus_event = {8'h77, 8'h11};
      bus.fifo_req = 2'b10;
      step();
      n_checks++;
      if (obs() !== expv() || bus.fifo_grant !== 2'b10 || bus.fifo_wr_data !== 8'h77)
         $display("FAIL drop_grant got %h want %h", obs(), expv());
      else n_pass++;
      bus.fifo_req = 2'b00;
      step();
      n_checks++;
      if (obs() !== expv() || bus.fifo_grant !== 2'b00 || bus.busy !== 1'b0 || bus.fifo_wr_data !== 8'h77)
         $display("FAIL drop_idle got %h want %h", obs(), expv());
      else n_pass++;
   endtask

   task automatic test_alternate();
      int age [2];
      bit winners [$];
      rst = 1'b1;
      step();
      rst = 1'b0;
      age[0] = 0;
      age[1] = 0;
      bus.fifo_req = 2'b11;
      for (int c = 0; c < 21; c++) begin
         bus.fifo_bus_event = 16'($urandom);
         step();
         n_checks++;
         if (obs() !== expv()) $display("FAIL alternate c%0d got %h want %h", c, obs(), expv());
         else n_pass++;
         if (bus.fifo_wr_en === 1'b1) winners.push_back(bus.fifo_grant == 2'b10);
         for (int i = 0; i < 2; i++) begin
            age[i] = bus.fifo_grant[i] ? age[i] + 1 : 0;
            bus.fifo_req[i] = (age[i] == 2) ? 1'b0 : 1'b1;
         end
      end
      n_checks++;
      if (winners.size() < 5) $display("FAIL alternate_count got %0d want >=5", winners.size());
      else n_pass++;
      foreach (winners[k]) begin
         n_checks++;
         if (winners[k] !== bit'(k % 2)) $display("FAIL alternate_order k%0d got %0d want %0d", k, winners[k], k % 2);
         else n_pass++;
      end
   endtask

   task automatic test_reset_release();
      bus.fifo_req = 2'b00;
      step();
      step();
      bus.fifo_bus_event = {8'h42, 8'h5E};
      bus.fifo_req = 2'b01;
      for (int c = 0; c < 2; c++) begin
         step();
         n_checks++;
         if (obs() !== expv()) $display("FAIL rst_release_pre c%0d got %h want %h", c, obs(), expv());
         else n_pass++;
      end
      rst = 1'b1;
      step();
      n_checks++;
      if (obs() !== 28'h0) $display("FAIL rst_release_abort got %h want %h", obs(), 28'h0);
      else n_pass++;
      rst = 1'b0;
      step();
      n_checks++;
      if (obs() !== {2'b01, 1'b1, 8'h5E, 1'b1, 16'd1})
         $display("FAIL rst_release_rearb got %h want %h", obs(), {2'b01, 1'b1, 8'h5E, 1'b1, 16'd1});
      else n_pass++;
      bus.fifo_req = 2'b00;
      step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bus.fifo_req = 2'($urandom);
         bus.fifo_full = ($urandom_range(0, 3) == 0);
         bus.fifo_bus_event = 16'($urandom);
         rst = ($urandom_range(0, 59) == 0);
         step();
         n_checks++;
         if (obs() !== expv() || !$onehot0(bus.fifo_grant))
            $display("FAIL random c%0d got %h want %h", c, obs(), expv());
         else n_pass++;
      end
      rst = 1'b0;
      bus.fifo_full = 1'b0;
      bus.fifo_req = 2'b00;
      step();
      step();
   endtask

   task automatic test_saturation();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      force dut.r_event_count = 16'hFFFD;
      #1;
      release dut.r_event_count;
      m_count = 16'hFFFD;
      for (int t = 0; t < 4; t++) begin
         bus.fifo_bus_event = 16'($urandom);
         bus.fifo_req = 2'($urandom_range(1, 3));
         step();
         n_checks++;
         if (obs() !== expv()) $display("FAIL sat_write t%0d got %h want %h", t, obs(), expv());
         else n_pass++;
         bus.fifo_req = 2'b00;
         step();
      end
      n_checks++;
      if (bus.event_count !== 16'hFFFF) $display("FAIL sat_final got %h want %h", bus.event_count, 16'hFFFF);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_drop_in_grant();
      test_alternate();
      test_reset_release();
      test_random();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
